// File: rtl/uart_frame_mux.sv
// Frame sequencer ahead of the 16-to-8 UART path: snapshots N_CH channels and emits
// sync word, N_CH tagged channel words and an XOR checksum word over valid/ready.
module uart_frame_mux #(
  parameter int unsigned       N_CH       = 5,
  parameter int unsigned       DATA_W     = 12,
  parameter int unsigned       TAG_W      = 4,
  parameter logic [TAG_W-1:0]  BASE_TAG   = 4'h3,
  parameter logic [TAG_W-1:0]  SYNC_TAG   = 4'hF,
  parameter logic [TAG_W-1:0]  CHK_TAG    = 4'hE,
  parameter bit                CONTINUOUS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic                     frame_req,
  output logic [TAG_W+DATA_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SNAP_W = N_CH * DATA_W;
  localparam int unsigned WORD_W = TAG_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_CHAN,
    S_CHK
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [DATA_W-1:0]   chk_q, chk_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                xfer_c;
  logic                last_chan_c;
  logic [DATA_W-1:0]   cnt_inc_c;
  logic [DATA_W-1:0]   nxt_pay_c;
  logic [TAG_W-1:0]    nxt_tag_c;

  assign xfer_c      = valid_q & out_ready;
  assign last_chan_c = (idx_q == IDX_W'(N_CH - 1));
  assign cnt_inc_c   = cnt_q + DATA_W'(1);

  // Payload and tag of the channel following the one currently presented
  always_comb begin
    nxt_pay_c = '0;
    nxt_tag_c = '0;
    for (int unsigned i = 1; i < N_CH; i++) begin
      if (32'(idx_q) + 32'd1 == i) begin
        nxt_pay_c = snap_q[i*DATA_W +: DATA_W];
        nxt_tag_c = TAG_W'(32'(BASE_TAG) + i);
      end
    end
  end

  // Next-state and next-output logic; the following word is loaded on the accepting edge
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CONTINUOUS || frame_req) begin
          snap_d  = ch_data;
          data_d  = {SYNC_TAG, cnt_q};
          chk_d   = cnt_q;
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (xfer_c) begin
          data_d  = {BASE_TAG, snap_q[DATA_W-1:0]};
          chk_d   = chk_q ^ snap_q[DATA_W-1:0];
          idx_d   = '0;
          state_d = S_CHAN;
        end
      end
      S_CHAN: begin
        if (xfer_c) begin
          if (!last_chan_c) begin
            data_d = {nxt_tag_c, nxt_pay_c};
            chk_d  = chk_q ^ nxt_pay_c;
            idx_d  = idx_q + IDX_W'(1);
          end else begin
            data_d  = {CHK_TAG, chk_q};
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (xfer_c) begin
          done_d = 1'b1;
          cnt_d  = cnt_inc_c;
          if (CONTINUOUS) begin
            // Back-to-back: the re-snapshot is the sample point of the next frame
            snap_d  = ch_data;
            data_d  = {SYNC_TAG, cnt_inc_c};
            chk_d   = cnt_inc_c;
            idx_d   = '0;
            state_d = S_SYNC;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
